// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the UART transmit arbiter:
//   - FSM state encoding (IDLE / SEND / DONE)
//   - payload type codes (byte / word)
//   - bytes-per-payload for raw and ASCII-hex output
//   - nibble-to-ASCII helper used by the hex print mode (TX_HEX_EN)
// -----------------------------------------------------------------------------
package tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic TYPE_BYTE = 1'b0;
   localparam logic TYPE_WORD = 1'b1;

   // Number of bytes put on the channel per payload.
   localparam logic [3:0] RAW_CNT_BYTE = 4'd1;
   localparam logic [3:0] RAW_CNT_WORD = 4'd4;
   localparam logic [3:0] HEX_CNT_BYTE = 4'd2;
   localparam logic [3:0] HEX_CNT_WORD = 4'd8;

   // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
   function automatic logic [7:0] nib2ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first requester at or after i_ptr,
// wrapping modulo NREQ.
//   i_req   [NREQ-1:0]  request vector
//   i_ptr   [PTR_W-1:0] scan start (always < NREQ)
//   o_found             at least one request is pending
//   o_win   [PTR_W-1:0] index of the winning requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
   import tx_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int PTR_W = 3
) (
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_found,
   output logic [PTR_W-1:0] o_win
);

   int w_idx;

   // Scan from the farthest offset down to offset 0 so the nearest
   // request at or after the pointer overwrites any later one.
   always_comb begin
      o_found = 1'b0;
      o_win   = '0;
      w_idx   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (i_req[w_idx]) begin
            o_found = 1'b1;
            o_win   = w_idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// -----------------------------------------------------------------------------
// tx_arbiter
// Shares the UART transmit byte channel among NREQ print requesters.
// A round-robin winner's byte/word payload is latched at grant and
// serialized onto vld_tx/d_tx; ack_tx pulses one cycle after the last byte.
//
// Handshake: a byte moves on every rising edge where vld_tx && rdy_tx; while
// rdy_tx is low, vld_tx and d_tx hold. Requesters hold req_tx until their
// one-cycle ack_tx pulse.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req_tx  [NREQ]  per-requester request
//   type_tx [NREQ]  payload type (0 byte, 1 word)
//   dout_tx [32*NREQ] per-requester payload, requester i at [32i+31:32i]
//   ack_tx  [NREQ]  one-hot completion pulse
//   rdy_tx          transmitter can take a byte
//   vld_tx, d_tx    outgoing byte
//   busy            state != IDLE
//   gnt_id  [PTR_W] current or last granted requester
//
// Build option: `define TX_HEX_EN prints the payload as ASCII hex, MSB
// nibble first (2 chars per byte, 8 per word). Default is raw bytes,
// LSB first.
// -----------------------------------------------------------------------------
module tx_arbiter
   import tx_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int PTR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_tx,
   input  logic [NREQ-1:0]    type_tx,
   input  logic [32*NREQ-1:0] dout_tx,
   output logic [NREQ-1:0]    ack_tx,
   input  logic               rdy_tx,
   output logic               vld_tx,
   output logic [7:0]         d_tx,
   output logic               busy,
   output logic [PTR_W-1:0]   gnt_id
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

   state_t           r_state;
   logic [31:0]      r_shift;   // remaining payload, next byte at the head
   logic [3:0]       r_left;    // bytes still to send after the current one
   logic             r_vld;
   logic [7:0]       r_d;
   logic [NREQ-1:0]  r_ack;
   logic             r_busy;
   logic [PTR_W-1:0] r_gnt;
   logic [PTR_W-1:0] r_ptr;

   logic             w_found;
   logic [PTR_W-1:0] w_win;
   logic [31:0]      w_din;
   logic             w_type;
   logic [3:0]       w_cnt;
   logic [31:0]      w_init_shift;
   logic [7:0]       w_init_byte;
   logic [31:0]      w_next_shift;
   logic [7:0]       w_next_byte;
   logic [NREQ-1:0]  w_ack_vec;
   logic [PTR_W-1:0] w_ptr_next;

   rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
      .i_req   (req_tx),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_win   (w_win)
   );

   // Payload/type of the current round-robin winner, plus one-hot ack.
   always_comb begin
      w_din     = '0;
      w_type    = TYPE_BYTE;
      w_ack_vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == i[PTR_W-1:0]) begin
            w_din  = dout_tx[32*i +: 32];
            w_type = type_tx[i];
         end
         w_ack_vec[i] = (r_gnt == i[PTR_W-1:0]);
      end
      w_ptr_next = (w_win == LAST) ? '0 : w_win + 1'b1;
   end

   // The payload lives in a shift register; the byte on d_tx is always
   // derived from its head, so only the shift direction and the head
   // mapping differ between the two print modes.
   always_comb begin
`ifdef TX_HEX_EN
      w_cnt        = (w_type == TYPE_WORD) ? HEX_CNT_WORD : HEX_CNT_BYTE;
      // A byte payload is moved to the top so its high nibble leads.
      w_init_shift = (w_type == TYPE_WORD) ? w_din : {w_din[7:0], 24'h0};
      w_init_byte  = nib2ascii(w_init_shift[31:28]);
      w_next_shift = r_shift << 4;
      w_next_byte  = nib2ascii(w_next_shift[31:28]);
`else
      w_cnt        = (w_type == TYPE_WORD) ? RAW_CNT_WORD : RAW_CNT_BYTE;
      w_init_shift = w_din;
      w_init_byte  = w_din[7:0];
      w_next_shift = r_shift >> 8;
      w_next_byte  = w_next_shift[7:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_left  <= '0;
         r_vld   <= 1'b0;
         r_d     <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
         r_gnt   <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= '0;
               if (w_found) begin
                  r_shift <= w_init_shift;
                  r_left  <= w_cnt - 4'd1;
                  r_d     <= w_init_byte;
                  r_vld   <= 1'b1;
                  r_busy  <= 1'b1;
                  r_gnt   <= w_win;
                  r_ptr   <= w_ptr_next;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (r_vld && rdy_tx) begin
                  if (r_left == 4'd0) begin
                     r_vld   <= 1'b0;
                     r_ack   <= w_ack_vec;
                     r_state <= ST_DONE;
                  end else begin
                     r_left  <= r_left - 4'd1;
                     r_shift <= w_next_shift;
                     r_d     <= w_next_byte;
                  end
               end
            end
            ST_DONE: begin
               // No grant here: requesters drop req at the edge that ends
               // this cycle, so re-arbitration waits for IDLE.
               r_ack   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack_tx = r_ack;
   assign vld_tx = r_vld;
   assign d_tx   = r_d;
   assign busy   = r_busy;
   assign gnt_id = r_gnt;

endmodule

// File: tb/tb_tx_arbiter.sv
module tb_tx_arbiter;

   localparam int NREQ  = 3;
   localparam int PTR_W = 3;

   // ---------------------------------------------------------------- clock/reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req_tx;
   logic [NREQ-1:0]    type_tx;
   logic [32*NREQ-1:0] dout_tx;
   logic [NREQ-1:0]    ack_tx;
   logic               rdy_tx;
   logic               vld_tx;
   logic [7:0]         d_tx;
   logic               busy;
   logic [PTR_W-1:0]   gnt_id;

   logic        tb_req  [NREQ];
   logic        tb_type [NREQ];
   logic [31:0] tb_dout [NREQ];

   always_comb begin
      req_tx  = '0;
      type_tx = '0;
      dout_tx = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_tx[i]           = tb_req[i];
         type_tx[i]          = tb_type[i];
         dout_tx[32*i +: 32] = tb_dout[i];
      end
   end

   tx_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_tx  (req_tx),
      .type_tx (type_tx),
      .dout_tx (dout_tx),
      .ack_tx  (ack_tx),
      .rdy_tx  (rdy_tx),
      .vld_tx  (vld_tx),
      .d_tx    (d_tx),
      .busy    (busy),
      .gnt_id  (gnt_id)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [7:0]       exp_q[$];
   logic [PTR_W-1:0] exp_ack_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------- rdy driver
   logic bp_mode = 1'b0;
   initial begin
      rdy_tx = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) rdy_tx = ~rdy_tx;
         else         rdy_tx = 1'b1;
      end
   end

   // ---------------------------------------------------------------- monitor
   logic       hold_pend = 1'b0;
   logic [7:0] hold_d;
   logic [PTR_W-1:0] mon_id;

   always @(negedge clk) begin
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (vld_tx && hold_pend) check("hold_stable", 32'(d_tx), 32'(hold_d));
         if (vld_tx && !rdy_tx) begin
            hold_pend = 1'b1;
            hold_d    = d_tx;
         end else begin
            hold_pend = 1'b0;
         end
         if (vld_tx && rdy_tx) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL byte_unexpected actual=%0h required=none", d_tx);
            end else begin
               check("byte", 32'(d_tx), 32'(exp_q.pop_front()));
            end
         end
         if (ack_tx != '0) begin
            if (exp_ack_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL ack_unexpected actual=%0h required=none", ack_tx);
            end else begin
               mon_id = exp_ack_q.pop_front();
               check("ack_vec", 32'(ack_tx), 32'(1) << mon_id);
               check("ack_gnt_id", 32'(gnt_id), 32'(mon_id));
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   // Called at posedge+1; returns at posedge+1 after the ack cycle.
   task automatic wait_ack(input int i);
      int t;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ack_tx[i]) break;
      end
      if (t == 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL ack_timeout req=%0d actual=none required=ack", i);
      end
      @(posedge clk);
      #1;
      tb_req[i] = 1'b0;
   endtask

   task automatic run_req(input int i, input logic typ, input logic [31:0] data);
      tb_type[i] = typ;
      tb_dout[i] = data;
      tb_req[i]  = 1'b1;
      wait_ack(i);
   endtask

   task automatic contend(input int i);
      logic [31:0] d;
      for (int r = 0; r < 2; r++) begin
         d = 32'((i + 1) * 16 + r);
         run_req(i, 1'b0, d);
      end
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      for (int i = 0; i < NREQ; i++) begin
         tb_req[i]  = 1'b0;
         tb_type[i] = 1'b0;
         tb_dout[i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_vld", 32'(vld_tx), 32'h0);
      check("rst_d", 32'(d_tx), 32'h0);
      check("rst_ack", 32'(ack_tx), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_gnt", 32'(gnt_id), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

`ifdef TX_HEX_EN
      // 0xDEADBEEF -> "DEADBEEF"
      exp_q.push_back(8'h44); exp_q.push_back(8'h45);
      exp_q.push_back(8'h41); exp_q.push_back(8'h44);
      exp_q.push_back(8'h42); exp_q.push_back(8'h45);
      exp_q.push_back(8'h45); exp_q.push_back(8'h46);
      exp_ack_q.push_back(3'd0);
      run_req(0, 1'b1, 32'hDEADBEEF);
      // byte 0x1F -> "1F"
      exp_q.push_back(8'h31); exp_q.push_back(8'h46);
      exp_ack_q.push_back(3'd1);
      run_req(1, 1'b0, 32'h0000001F);
`else
      // Single byte with cycle-exact latency.
      exp_q.push_back(8'hA5);
      exp_ack_q.push_back(3'd0);
      tb_type[0] = 1'b0;
      tb_dout[0] = 32'h000000A5;
      tb_req[0]  = 1'b1;
      @(negedge clk);
      check("t1_c0_vld", 32'(vld_tx), 32'h0);
      @(negedge clk);
      check("t1_c1_vld", 32'(vld_tx), 32'h1);
      check("t1_c1_busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("t1_c2_ack", 32'(ack_tx), 32'h1);
      check("t1_c2_vld", 32'(vld_tx), 32'h0);
      @(posedge clk);
      #1;
      tb_req[0] = 1'b0;
      @(negedge clk);
      check("t1_c3_busy", 32'(busy), 32'h0);
      check("t1_c3_ack", 32'(ack_tx), 32'h0);
      @(posedge clk);
      #1;

      // Word with alternating backpressure (pointer now 1).
      exp_q.push_back(8'h78); exp_q.push_back(8'h56);
      exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      exp_ack_q.push_back(3'd1);
      bp_mode = 1'b1;
      run_req(1, 1'b1, 32'h12345678);
      bp_mode = 1'b0;

      // Payload/type change after grant (pointer now 2).
      exp_q.push_back(8'hC3);
      exp_ack_q.push_back(3'd2);
      tb_type[2] = 1'b0;
      tb_dout[2] = 32'h000000C3;
      tb_req[2]  = 1'b1;
      @(posedge clk);
      #1;
      tb_dout[2] = 32'hFFFFFFFF;
      tb_type[2] = 1'b1;
      wait_ack(2);

      // Contention, pointer now 0: grants 0,1,2,0,1,2.
      exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
      exp_q.push_back(8'h11); exp_q.push_back(8'h21); exp_q.push_back(8'h31);
      exp_ack_q.push_back(3'd0); exp_ack_q.push_back(3'd1); exp_ack_q.push_back(3'd2);
      exp_ack_q.push_back(3'd0); exp_ack_q.push_back(3'd1); exp_ack_q.push_back(3'd2);
      fork
         contend(0);
         contend(1);
         contend(2);
      join
      @(posedge clk);
      #1;

      // Reset after two of four bytes.
      exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
      tb_type[1] = 1'b1;
      tb_dout[1] = 32'hAABBCCDD;
      tb_req[1]  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b1;
      tb_req[1] = 1'b0;
      #1;
      check("midrst_vld", 32'(vld_tx), 32'h0);
      check("midrst_ack", 32'(ack_tx), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_gnt", 32'(gnt_id), 32'h0);
      check("midrst_bytes_seen", 32'(exp_q.size()), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(8'h04); exp_q.push_back(8'h03);
      exp_q.push_back(8'h02); exp_q.push_back(8'h01);
      exp_ack_q.push_back(3'd2);
      run_req(2, 1'b1, 32'h01020304);
`endif

      repeat (5) @(posedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'h0);
      check("exp_ack_q_empty", 32'(exp_ack_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single UART transmit byte channel (vld_tx/rdy_tx/d_tx) among NREQ print requesters: command echo, memory-dump printer, error reporter.
- Each requester posts a byte or a 32-bit word with a request/ack handshake.
- The block grants one requester at a time, round-robin, and serializes its payload LSB-first onto the byte channel.
- Sits between the debug-unit command logic and the UART transmitter.

Parameters:
- NREQ, 3, number of requesters (2..8).
- PTR_W, 3, width of the round-robin pointer and grant id; must satisfy 2^PTR_W >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_tx  in  NREQ  per-requester request; held high until the matching ack_tx.
- type_tx  in  NREQ  per-requester payload type: 0 = byte, 1 = word.
- dout_tx  in  32*NREQ  per-requester payload; requester i uses bits [32i+31:32i].
- ack_tx  out  NREQ  one-cycle completion pulse, one-hot.
- rdy_tx  in  1  UART transmitter can accept a byte this cycle.
- vld_tx  out  1  d_tx is valid.
- d_tx  out  8  byte to transmit.
- busy  out  1  a transfer is in progress (state != IDLE).
- gnt_id  out  PTR_W  index of the current or last granted requester.

Behaviour:
- All outputs are registered.
- Reset: state = IDLE, vld_tx = 0, d_tx = 0, ack_tx = 0, busy = 0, gnt_id = 0, rr pointer = 0. Reset mid-transfer aborts the transfer silently; no ack is issued.
- States: IDLE, SEND, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req high:
  - Choose the first requester at or after the rr pointer, wrapping modulo NREQ.
  - Latch its dout_tx and type_tx into internal registers.
  - Byte count = 1 for type 0, 4 for type 1; byte index = 0.
  - Set gnt_id; pointer = winner+1 mod NREQ.
  - Go to SEND with vld_tx = 1 and d_tx = byte0 on the next cycle.
- SEND:
  - A byte transfers on any clock edge where vld_tx && rdy_tx.
  - While rdy_tx = 0, vld_tx and d_tx hold stable.
  - On a transfer that is not the last byte: index increments and d_tx is updated to the next byte (bits [8k+7:8k]). vld_tx stays high; no bubble.
  - On the last transfer: vld_tx = 0, go to DONE.
- DONE: ack_tx[gnt_id] = 1 for exactly one cycle, then go to IDLE. The requester drops req_tx at the edge where it samples ack. IDLE never re-grants in the DONE cycle.
- Latency with rdy_tx held high:
  - Byte: req at cycle 0 -> vld cycle 1 -> ack cycle 2 -> IDLE cycle 3.
  - Word: vld cycles 1-4 -> ack cycle 5.
- Payload and type are sampled only at grant. Later changes to dout_tx/type_tx, or req_tx dropping mid-transfer, have no effect; the transfer completes and ack is still pulsed.
- Simultaneous requests: strict round-robin. No requester is starved; the worst-case wait is NREQ-1 transfers.
- Requests with index >= NREQ do not exist. Pointer wrap: NREQ-1 -> 0.

Optional Feature:
- Macro TX_HEX_EN.
- Defined: the payload is printed as ASCII hex, MSB nibble first, digits '0'-'9' and 'A'-'F'. Byte = 2 chars, word = 8 chars. For 0x1F, d_tx sequence = 0x31, 0x46.
- Not defined: raw binary bytes, LSB-first, counts 1/4.
- Handshake, states and ack timing are identical in both builds; only the byte count and the byte mapping differ.

Decomposition:
- Shared package tx_pkg:
  - state encoding (IDLE/SEND/DONE);
  - TYPE_BYTE = 0, TYPE_WORD = 1;
  - byte counts for raw and hex modes;
  - nibble-to-ASCII function.
- Sub-module rr_arbiter:
  - combinational round-robin pick from req vector and pointer;
  - outputs found flag and winner index.

Test Plan:
- Single byte: req0, type 0, dout 0x000000A5, rdy_tx = 1. Required: d_tx = 0xA5 with vld for exactly 1 cycle; ack_tx = 001 two cycles after req; busy low again at cycle 3.
- Word with backpressure: req1, type 1, dout 0x12345678, rdy_tx low on alternate cycles. Required: d_tx sequence 0x78, 0x56, 0x34, 0x12; each byte held stable while rdy is low; one ack_tx = 010 after the 4th transfer.
- Contention: req0, req1, req2 all high at once, each byte type, each requester re-requests immediately after its ack. Required: grant order 0, 1, 2, 0, 1, 2; no requester granted twice in a row while others wait.
- Payload change: change dout_tx and type_tx in the cycle after grant. Required: the originally latched value is transmitted.
- Reset mid-word: assert rst after 2 of 4 bytes. Required: vld_tx, ack_tx, busy = 0 immediately. After release, the next req2 is granted first (pointer = 0 scan) and sends a full payload.
- TX_HEX_EN build: word 0xDEADBEEF. Required: 8 bytes 'D','E','A','D','B','E','E','F' (0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46), then ack.
